// File: rtl/hazard_unit_pkg.sv
// Shared types, widths and hazard-select bit positions for the TSC pipeline hazard unit.
package hazard_unit_pkg;

    localparam int unsigned REG_ADDR_W = 2;
    localparam int unsigned HZ_W       = 6;
    localparam int unsigned NUM_SRC    = 3;

    localparam int unsigned HAZARD_EX_RS  = 0;
    localparam int unsigned HAZARD_MEM_RS = 1;
    localparam int unsigned HAZARD_WB_RS  = 2;
    localparam int unsigned HAZARD_EX_RT  = 3;
    localparam int unsigned HAZARD_MEM_RT = 4;
    localparam int unsigned HAZARD_WB_RT  = 5;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [HZ_W-1:0]       hz_vec_t;
    typedef logic [NUM_SRC-1:0]    src_sel_t;

    // One pipeline stage as a potential producer of a register value.
    typedef struct packed {
        reg_idx_t dest;
        logic     we;
    } producer_t;

    function automatic logic reg_match(input producer_t p, input reg_idx_t r);
        return p.we && (p.dest == r);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side bundle of dependence inputs and hazard outputs of hazard_unit.
interface hazard_unit_if;
    import hazard_unit_pkg::*;

    reg_idx_t rs_if_i;
    logic     is_jump_rs_i;
    reg_idx_t rs_id_i;
    reg_idx_t rt_id_i;
    logic     use_rs_i;
    logic     use_rt_i;
    reg_idx_t dest_id_i;
    reg_idx_t dest_ex_i;
    reg_idx_t dest_mem_i;
    reg_idx_t dest_wb_i;
    logic     reg_write_id_i;
    logic     reg_write_ex_i;
    logic     reg_write_mem_i;
    logic     reg_write_wb_i;
    logic     ex_load_i;
    logic     flush_i;
    hz_vec_t  hazard_signal_if_o;
    hz_vec_t  hazard_signal_id_o;
    hz_vec_t  hazard_signal_ex_o;
    logic     stall_pc_o;
    logic     stall_o;

    modport master (
        output rs_if_i, is_jump_rs_i, rs_id_i, rt_id_i, use_rs_i, use_rt_i,
               dest_id_i, dest_ex_i, dest_mem_i, dest_wb_i,
               reg_write_id_i, reg_write_ex_i, reg_write_mem_i, reg_write_wb_i,
               ex_load_i, flush_i,
        input  hazard_signal_if_o, hazard_signal_id_o, hazard_signal_ex_o,
               stall_pc_o, stall_o
    );

    modport slave (
        input  rs_if_i, is_jump_rs_i, rs_id_i, rt_id_i, use_rs_i, use_rt_i,
               dest_id_i, dest_ex_i, dest_mem_i, dest_wb_i,
               reg_write_id_i, reg_write_ex_i, reg_write_mem_i, reg_write_wb_i,
               ex_load_i, flush_i,
        output hazard_signal_if_o, hazard_signal_id_o, hazard_signal_ex_o,
               stall_pc_o, stall_o
    );

endinterface

// File: rtl/hazard_unit_match_prio.sv
// Nearest-producer select for one consumer register: one-hot {far, mid, near} or zero.
module hazard_match_prio
    import hazard_unit_pkg::*;
(
    input  reg_idx_t  idx_i,
    input  logic      en_i,
    input  producer_t near_i,
    input  producer_t mid_i,
    input  producer_t far_i,
    output src_sel_t  sel_c_o
);

    always_comb begin
        sel_c_o = '0;
        if (en_i) begin
            if (reg_match(near_i, idx_i)) begin
                sel_c_o[0] = 1'b1;
            end else if (reg_match(mid_i, idx_i)) begin
                sel_c_o[1] = 1'b1;
            end else if (reg_match(far_i, idx_i)) begin
                sel_c_o[2] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forward-select generation for the 5-stage TSC pipeline,
// with the ID selects registered for the EX-stage operand muxes.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    hazard_unit_if.slave hz
);

    producer_t prod_id;
    producer_t prod_ex;
    producer_t prod_ex_jr;
    producer_t prod_mem;
    producer_t prod_wb;

    src_sel_t  sel_if_c;
    src_sel_t  sel_rs_c;
    src_sel_t  sel_rt_c;
    hz_vec_t   hz_id_c;
    logic      stall_c;

    hz_vec_t   hazard_signal_ex_d;
    hz_vec_t   hazard_signal_ex_q;

    assign prod_id  = '{dest: hz.dest_id_i,  we: hz.reg_write_id_i};
    assign prod_ex  = '{dest: hz.dest_ex_i,  we: hz.reg_write_ex_i};
    assign prod_mem = '{dest: hz.dest_mem_i, we: hz.reg_write_mem_i};
    assign prod_wb  = '{dest: hz.dest_wb_i,  we: hz.reg_write_wb_i};

    // A load in EX has no data yet, so it is not a forwarding source for the jump target.
    assign prod_ex_jr = '{dest: hz.dest_ex_i, we: hz.reg_write_ex_i && !hz.ex_load_i};

    hazard_match_prio u_prio_if (
        .idx_i   (hz.rs_if_i),
        .en_i    (hz.is_jump_rs_i),
        .near_i  (prod_ex_jr),
        .mid_i   (prod_mem),
        .far_i   (prod_wb),
        .sel_c_o (sel_if_c)
    );

    hazard_match_prio u_prio_rs (
        .idx_i   (hz.rs_id_i),
        .en_i    (hz.use_rs_i),
        .near_i  (prod_id),
        .mid_i   (prod_ex),
        .far_i   (prod_mem),
        .sel_c_o (sel_rs_c)
    );

    hazard_match_prio u_prio_rt (
        .idx_i   (hz.rt_id_i),
        .en_i    (hz.use_rt_i),
        .near_i  (prod_id),
        .mid_i   (prod_ex),
        .far_i   (prod_mem),
        .sel_c_o (sel_rt_c)
    );

    assign hz_id_c = {sel_rt_c, sel_rs_c};

    assign stall_c = hz.ex_load_i &&
                     ((hz.use_rs_i && reg_match(prod_ex, hz.rs_id_i)) ||
                      (hz.use_rt_i && reg_match(prod_ex, hz.rt_id_i)));

    assign hz.hazard_signal_if_o = HZ_W'(sel_if_c);
    assign hz.hazard_signal_id_o = hz_id_c;
    assign hz.stall_o            = stall_c;
    assign hz.stall_pc_o         = hz.is_jump_rs_i &&
                                   (reg_match(prod_id, hz.rs_if_i) ||
                                    (hz.ex_load_i && reg_match(prod_ex, hz.rs_if_i)));

    // A stall or flush sends a bubble into EX, which must not forward anything.
    always_comb begin
        hazard_signal_ex_d = hz_id_c;
        if (stall_c || hz.flush_i) begin
            hazard_signal_ex_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hazard_signal_ex_q <= '0;
        end else begin
            hazard_signal_ex_q <= hazard_signal_ex_d;
        end
    end

    assign hz.hazard_signal_ex_o = hazard_signal_ex_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus a randomised scoreboard run.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    typedef struct packed {
        logic [1:0] rs_if;
        logic       jr;
        logic [1:0] rs_id;
        logic [1:0] rt_id;
        logic       use_rs;
        logic       use_rt;
        logic [1:0] dest_id;
        logic [1:0] dest_ex;
        logic [1:0] dest_mem;
        logic [1:0] dest_wb;
        logic       rw_id;
        logic       rw_ex;
        logic       rw_mem;
        logic       rw_wb;
        logic       ex_load;
        logic       flush;
    } stim_t;

    typedef struct packed {
        logic [5:0] hif;
        logic [5:0] hid;
        logic       spc;
        logic       st;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hazard_unit_if hz();

    hazard_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    exp_t       comb_q[$];
    logic [5:0] ex_q[$];
    int         errors = 0;
    int         checks = 0;
    exp_t       e;
    logic [5:0] x;
    stim_t      s;

    // Reference model, written bit by bit from the select rules.
    function automatic exp_t model(input stim_t t);
        exp_t r;
        logic ex_hit_if, id_hit_if;
        r = '0;
        ex_hit_if = t.rw_ex && (t.dest_ex == t.rs_if);
        id_hit_if = t.rw_id && (t.dest_id == t.rs_if);
        if (t.jr) begin
            if (ex_hit_if && !t.ex_load)                   r.hif = 6'b000001;
            else if (t.rw_mem && t.dest_mem == t.rs_if)    r.hif = 6'b000010;
            else if (t.rw_wb && t.dest_wb == t.rs_if)      r.hif = 6'b000100;
        end
        r.spc = t.jr && (id_hit_if || (t.ex_load && ex_hit_if));
        if (t.use_rs) begin
            if (t.rw_id && t.dest_id == t.rs_id)           r.hid[0] = 1'b1;
            else if (t.rw_ex && t.dest_ex == t.rs_id)      r.hid[1] = 1'b1;
            else if (t.rw_mem && t.dest_mem == t.rs_id)    r.hid[2] = 1'b1;
        end
        if (t.use_rt) begin
            if (t.rw_id && t.dest_id == t.rt_id)           r.hid[3] = 1'b1;
            else if (t.rw_ex && t.dest_ex == t.rt_id)      r.hid[4] = 1'b1;
            else if (t.rw_mem && t.dest_mem == t.rt_id)    r.hid[5] = 1'b1;
        end
        r.st = t.ex_load && t.rw_ex &&
               ((t.use_rs && t.dest_ex == t.rs_id) || (t.use_rt && t.dest_ex == t.rt_id));
        return r;
    endfunction

    task automatic drive(input stim_t t);
        exp_t m;
        hz.rs_if_i         = t.rs_if;
        hz.is_jump_rs_i    = t.jr;
        hz.rs_id_i         = t.rs_id;
        hz.rt_id_i         = t.rt_id;
        hz.use_rs_i        = t.use_rs;
        hz.use_rt_i        = t.use_rt;
        hz.dest_id_i       = t.dest_id;
        hz.dest_ex_i       = t.dest_ex;
        hz.dest_mem_i      = t.dest_mem;
        hz.dest_wb_i       = t.dest_wb;
        hz.reg_write_id_i  = t.rw_id;
        hz.reg_write_ex_i  = t.rw_ex;
        hz.reg_write_mem_i = t.rw_mem;
        hz.reg_write_wb_i  = t.rw_wb;
        hz.ex_load_i       = t.ex_load;
        hz.flush_i         = t.flush;
        m = model(t);
        comb_q.push_back(m);
        ex_q.push_back((t.flush || m.st) ? 6'b0 : m.hid);
    endtask

    task automatic test_reset();
        s = '0;
        s.use_rs = 1'b1; s.rs_id = 2'd1; s.dest_ex = 2'd1; s.rw_ex = 1'b1;
        drive(s);
        #2;
        e = comb_q.pop_front();
        checks++;
        if (hz.hazard_signal_ex_o !== 6'b0) begin
            errors++; $display("FAIL reset_ex: got %b want %b", hz.hazard_signal_ex_o, 6'b0);
        end
        checks++;
        if (hz.hazard_signal_id_o !== e.hid) begin
            errors++; $display("FAIL reset_comb_id: got %b want %b", hz.hazard_signal_id_o, e.hid);
        end
        @(posedge clk); #1;
        x = ex_q.pop_front();
        checks++;
        if (hz.hazard_signal_ex_o !== 6'b0) begin
            errors++; $display("FAIL reset_ex_clk: got %b want %b", hz.hazard_signal_ex_o, 6'b0);
        end
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_forwarding();
        s = '0;
        s.use_rs = 1'b1; s.rs_id = 2'd1; s.dest_id = 2'd1; s.rw_id = 1'b1;
        s.dest_ex = 2'd1; s.rw_ex = 1'b1;
        drive(s);
        #2;
        e = comb_q.pop_front();
        checks++;
        if (hz.hazard_signal_id_o !== 6'b000001 || hz.hazard_signal_id_o !== e.hid) begin
            errors++; $display("FAIL fwd_id: got %b want %b", hz.hazard_signal_id_o, 6'b000001);
        end
        @(posedge clk); #1;
        x = ex_q.pop_front();
        checks++;
        if (hz.hazard_signal_ex_o !== 6'b000001 || hz.hazard_signal_ex_o !== x) begin
            errors++; $display("FAIL fwd_ex: got %b want %b", hz.hazard_signal_ex_o, 6'b000001);
        end
    endtask

    task automatic test_load_use();
        s = '0;
        s.ex_load = 1'b1; s.rw_ex = 1'b1; s.dest_ex = 2'd2; s.use_rt = 1'b1; s.rt_id = 2'd2;
        drive(s);
        #2;
        e = comb_q.pop_front();
        checks++;
        if (hz.stall_o !== 1'b1) begin
            errors++; $display("FAIL load_use_stall: got %b want %b", hz.stall_o, 1'b1);
        end
        checks++;
        if (hz.hazard_signal_id_o !== e.hid) begin
            errors++; $display("FAIL load_use_id: got %b want %b", hz.hazard_signal_id_o, e.hid);
        end
        @(posedge clk); #1;
        x = ex_q.pop_front();
        checks++;
        if (hz.hazard_signal_ex_o !== 6'b0 || hz.hazard_signal_ex_o !== x) begin
            errors++; $display("FAIL load_use_ex: got %b want %b", hz.hazard_signal_ex_o, 6'b0);
        end
    endtask

    task automatic test_jump_id();
        s = '0;
        s.jr = 1'b1; s.rs_if = 2'd3; s.dest_id = 2'd3; s.rw_id = 1'b1;
        drive(s);
        #2;
        e = comb_q.pop_front();
        checks++;
        if (hz.stall_pc_o !== 1'b1) begin
            errors++; $display("FAIL jr_id_stall_pc: got %b want %b", hz.stall_pc_o, 1'b1);
        end
        checks++;
        if (hz.hazard_signal_if_o !== 6'b0) begin
            errors++; $display("FAIL jr_id_if: got %b want %b", hz.hazard_signal_if_o, 6'b0);
        end
        @(posedge clk); #1;
        x = ex_q.pop_front();
    endtask

    task automatic test_jump_mem();
        s = '0;
        s.jr = 1'b1; s.rs_if = 2'd0; s.dest_mem = 2'd0; s.rw_mem = 1'b1;
        drive(s);
        #2;
        e = comb_q.pop_front();
        checks++;
        if (hz.hazard_signal_if_o !== 6'b000010) begin
            errors++; $display("FAIL jr_mem_if: got %b want %b", hz.hazard_signal_if_o, 6'b000010);
        end
        checks++;
        if (hz.stall_pc_o !== 1'b0) begin
            errors++; $display("FAIL jr_mem_stall_pc: got %b want %b", hz.stall_pc_o, 1'b0);
        end
        @(posedge clk); #1;
        x = ex_q.pop_front();
    endtask

    task automatic test_jump_ex_load();
        s = '0;
        s.jr = 1'b1; s.rs_if = 2'd1; s.dest_ex = 2'd1; s.rw_ex = 1'b1; s.ex_load = 1'b1;
        s.dest_wb = 2'd1; s.rw_wb = 1'b1;
        drive(s);
        #2;
        e = comb_q.pop_front();
        checks++;
        if (hz.stall_pc_o !== 1'b1 || hz.hazard_signal_if_o !== 6'b000100) begin
            errors++; $display("FAIL jr_ex_load: got spc=%b if=%b want spc=1 if=000100",
                               hz.stall_pc_o, hz.hazard_signal_if_o);
        end
        @(posedge clk); #1;
        x = ex_q.pop_front();
    endtask

    task automatic test_flush();
        s = '0;
        s.use_rt = 1'b1; s.rt_id = 2'd1; s.dest_id = 2'd1; s.rw_id = 1'b1; s.flush = 1'b1;
        drive(s);
        #2;
        e = comb_q.pop_front();
        checks++;
        if (hz.hazard_signal_id_o !== 6'b001000) begin
            errors++; $display("FAIL flush_id: got %b want %b", hz.hazard_signal_id_o, 6'b001000);
        end
        @(posedge clk); #1;
        x = ex_q.pop_front();
        checks++;
        if (hz.hazard_signal_ex_o !== 6'b0) begin
            errors++; $display("FAIL flush_ex: got %b want %b", hz.hazard_signal_ex_o, 6'b0);
        end
    endtask

    task automatic test_flush_stall();
        s = '0;
        s.ex_load = 1'b1; s.rw_ex = 1'b1; s.dest_ex = 2'd0; s.use_rs = 1'b1; s.rs_id = 2'd0;
        s.flush = 1'b1;
        drive(s);
        #2;
        e = comb_q.pop_front();
        checks++;
        if (hz.stall_o !== 1'b1) begin
            errors++; $display("FAIL flush_stall_stall: got %b want %b", hz.stall_o, 1'b1);
        end
        @(posedge clk); #1;
        x = ex_q.pop_front();
        checks++;
        if (hz.hazard_signal_ex_o !== 6'b0) begin
            errors++; $display("FAIL flush_stall_ex: got %b want %b", hz.hazard_signal_ex_o, 6'b0);
        end
    endtask

    task automatic test_rs_eq_rt();
        s = '0;
        s.use_rs = 1'b1; s.use_rt = 1'b1; s.rs_id = 2'd2; s.rt_id = 2'd2;
        s.dest_mem = 2'd2; s.rw_mem = 1'b1;
        drive(s);
        #2;
        e = comb_q.pop_front();
        checks++;
        if (hz.hazard_signal_id_o !== 6'b100100) begin
            errors++; $display("FAIL rs_eq_rt_id: got %b want %b", hz.hazard_signal_id_o, 6'b100100);
        end
        @(posedge clk); #1;
        x = ex_q.pop_front();
        checks++;
        if (hz.hazard_signal_ex_o !== 6'b100100) begin
            errors++; $display("FAIL rs_eq_rt_ex: got %b want %b", hz.hazard_signal_ex_o, 6'b100100);
        end
    endtask

    task automatic test_async_reset();
        s = '0;
        s.use_rs = 1'b1; s.rs_id = 2'd3; s.dest_ex = 2'd3; s.rw_ex = 1'b1;
        drive(s);
        #2;
        e = comb_q.pop_front();
        @(posedge clk); #1;
        x = ex_q.pop_front();
        checks++;
        if (hz.hazard_signal_ex_o !== 6'b000010) begin
            errors++; $display("FAIL async_pre: got %b want %b", hz.hazard_signal_ex_o, 6'b000010);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (hz.hazard_signal_ex_o !== 6'b0) begin
            errors++; $display("FAIL async_reset_ex: got %b want %b", hz.hazard_signal_ex_o, 6'b0);
        end
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        for (int i = 0; i < 60; i++) begin
            r = $urandom;
            s = r[$bits(stim_t)-1:0];
            drive(s);
            #2;
            e = comb_q.pop_front();
            checks++;
            if (hz.hazard_signal_if_o !== e.hif) begin
                errors++; $display("FAIL rnd_if[%0d]: got %b want %b", i, hz.hazard_signal_if_o, e.hif);
            end
            checks++;
            if (hz.hazard_signal_id_o !== e.hid) begin
                errors++; $display("FAIL rnd_id[%0d]: got %b want %b", i, hz.hazard_signal_id_o, e.hid);
            end
            checks++;
            if (hz.stall_pc_o !== e.spc) begin
                errors++; $display("FAIL rnd_stall_pc[%0d]: got %b want %b", i, hz.stall_pc_o, e.spc);
            end
            checks++;
            if (hz.stall_o !== e.st) begin
                errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, hz.stall_o, e.st);
            end
            @(posedge clk); #1;
            x = ex_q.pop_front();
            checks++;
            if (hz.hazard_signal_ex_o !== x) begin
                errors++; $display("FAIL rnd_ex[%0d]: got %b want %b", i, hz.hazard_signal_ex_o, x);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_jump_id();
        test_jump_mem();
        test_jump_ex_load();
        test_flush();
        test_flush_stall();
        test_rs_eq_rt();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
